movavg_serial: RTL and testbench
================================

Name: movavg_serial

Overview:
- Four-tap moving-sum filter on 64-bit words, computed bit-serially.
- One input word is accepted per 64-cycle frame. Each word is converted parallel-to-serial (LSB first) and passed through three 64-cycle serial delay taps.
- The current word and the three taps feed a tree of bit-serial adders. The serial sum is converted back to parallel and presented on dout once per frame.
- Sits in the datapath as a low-area, one-sample-per-64-clocks averaging front end. Division by 4 is left to the consumer: dout[63:2] is the average.

Parameters:
- W, 64, data word width; also the frame length in clock cycles.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- din  input  W  parallel input word; sampled once per frame, at frame cycle 0.
- dout  output  W  parallel moving sum; registered; changes only on frame-boundary edges.

Behaviour:
- Frame counter cnt, 0..W-1, wraps 63→0. On reset: cnt=0. The first rising edge with reset=1 is frame cycle 0 of frame 0.
- At frame cycle 0 (edge E_n), din is loaded into the input shift register. Bits shift out LSB first, one per cycle, during the 64 cycles of frame n.
- Taps: tap1/tap2/tap3 are serial delay lines of W bits each (3×W flops total). tapk streams the word from frame n−k, bit-aligned with the current stream.
- Adders:
  - Three bit-serial adders, each with a 1-bit carry flop.
  - Each carry is forced to 0 for bit 0 of every frame, i.e. cleared at frame cycle 0.
  - Sum = in + tap1 + tap2 + tap3, modulo 2^W; carry-out of bit W−1 is discarded.
- Output assembly:
  - Each serial sum bit is shifted into a W-bit result register.
  - On edge E_{n+1}, the complete sum for frame n is transferred to dout, including the bit completing at that edge: dout <= din[n] + din[n−1] + din[n−2] + din[n−3].
  - dout is held constant for the next 64 cycles.
- Latency: the sum containing word n appears on dout at E_{n+1}, 64 cycles after capture. The value is valid from E_{n+1}+1 through E_{n+2}.
- Startup: reset clears all shift registers, taps, carries and dout to 0. Missing history therefore counts as zero; the frame-0 result equals din[0].
- din is ignored on cycles 1..63 of a frame; changes there have no effect.
- Reset mid-frame:
  - On the next edge: dout=0, all taps and carries cleared, cnt=0.
  - Partial serial results are discarded.
  - The frame restarts at the first edge after release.
- Reset has priority over all other updates.
- No handshake; the upstream must present a new word every 64 cycles and hold it at least through frame cycle 0.

Test Plan:
- Reset held 3 cycles, then released with din=0 → dout=0 for all subsequent frames; no X on any output.
- Impulse: frame0 din=0x1, frames 1..7 din=0 → dout=0x1 after E1, E2, E3, E4; dout=0x0 from E5 onward.
- Overflow: four frames of din=0xFFFFFFFFFFFFFFFF → after E4, dout=0xFFFFFFFFFFFFFFFC (wraps mod 2^64). Following zero frame → dout=0xFFFFFFFFFFFFFFFD after E5 (only three ones remain in window).
- Carry chain: frame0 din=0x7FFFFFFFFFFFFFFF, frame1 din=0x1 → after E2, dout=0x8000000000000000; carry must not leak into the next frame's bit 0.
- Reset mid-operation: after four nonzero frames, assert reset at frame cycle 30 for 1 cycle → dout=0 the next edge. Then din=0x5 at frame 0 → dout=0x5 after E1 (taps cleared).
- Random: 1024 frames of 64-bit $random words → every dout sampled 4 cycles after a frame boundary equals the software sum of the last four words mod 2^64.

Source files
------------

// File: rtl/movavg_serial.sv
// ---------------------------------------------------------------------------
// movavg_serial
//   Four-tap moving-sum filter on W-bit words, computed bit-serially.
//   One word is accepted per W-cycle frame, serialised LSB first, delayed
//   through three W-bit serial taps, summed by a tree of three bit-serial
//   adders and reassembled into a parallel word on dout once per frame.
//   dout[W-1:2] is the four-sample average.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   din    parallel input word, sampled at frame cycle 0
//   dout   registered moving sum din[n]+din[n-1]+din[n-2]+din[n-3] mod 2^W,
//          updated only on frame-boundary edges
// ---------------------------------------------------------------------------
module movavg_serial #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int unsigned CW = $clog2(W);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  in_q, in_d;
    logic [W-1:0]  tap1_q, tap1_d;
    logic [W-1:0]  tap2_q, tap2_d;
    logic [W-1:0]  tap3_q, tap3_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          c1_q, c1_d;
    logic          c2_q, c2_d;
    logic          c3_q, c3_d;

    logic          frame_start;
    logic          s1, s2, s3;
    logic          co1, co2, co3;

    always_comb begin
        frame_start = (cnt_q == '0);
        cnt_d       = (cnt_q == CW'(W - 1)) ? '0 : cnt_q + CW'(1);

        // Adder tree: (in + tap1) + (tap2 + tap3), one bit per cycle.
        s1  = in_q[0] ^ tap1_q[0] ^ c1_q;
        co1 = (in_q[0] & tap1_q[0]) | (in_q[0] & c1_q) | (tap1_q[0] & c1_q);
        s2  = tap2_q[0] ^ tap3_q[0] ^ c2_q;
        co2 = (tap2_q[0] & tap3_q[0]) | (tap2_q[0] & c2_q) | (tap3_q[0] & c2_q);
        s3  = s1 ^ s2 ^ c3_q;
        co3 = (s1 & s2) | (s1 & c3_q) | (s2 & c3_q);

        // The bit in flight at the frame-start edge is bit W-1 of the
        // previous word; it still feeds the taps while the new word loads.
        in_d   = frame_start ? din : {1'b0, in_q[W-1:1]};
        tap1_d = {in_q[0],   tap1_q[W-1:1]};
        tap2_d = {tap1_q[0], tap2_q[W-1:1]};
        tap3_d = {tap2_q[0], tap3_q[W-1:1]};
        res_d  = {s3, res_q[W-1:1]};

        // Final sum bit completes on the frame-start edge, so dout takes
        // the shifted result including it.
        dout_d = frame_start ? res_d : dout_q;

        // Carry out of bit W-1 is dropped; bit 0 starts with no carry.
        c1_d = frame_start ? 1'b0 : co1;
        c2_d = frame_start ? 1'b0 : co2;
        c3_d = frame_start ? 1'b0 : co3;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            in_q   <= '0;
            tap1_q <= '0;
            tap2_q <= '0;
            tap3_q <= '0;
            res_q  <= '0;
            dout_q <= '0;
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
            c3_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            in_q   <= in_d;
            tap1_q <= tap1_d;
            tap2_q <= tap2_d;
            tap3_q <= tap3_d;
            res_q  <= res_d;
            dout_q <= dout_d;
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            c3_q   <= c3_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_movavg_serial.sv
module tb_movavg_serial;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] ONES = '1;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic [W-1:0] dout;

    int unsigned n_checks;
    int unsigned n_errors;

    movavg_serial #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hold reset low for n edges; release so the next posedge is frame cycle 0.
    task automatic do_reset(input int unsigned n);
        @(negedge clk);
        reset = 1'b0;
        din   = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One frame: present w for the frame-start edge, check dout just after
    // that edge against exp, then scramble din for the rest of the frame
    // (those cycles must be ignored) and check dout holds.
    task automatic frame(input logic [W-1:0] w, input logic [W-1:0] exp, input string tag);
        din = w;
        @(posedge clk);
        #1;
        chk(tag, dout, exp);
        din = {$urandom, $urandom};
        repeat (31) @(posedge clk);
        #1;
        chk({tag, "_hold"}, dout, exp);
        repeat (32) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] h1, h2, h3, h4, w;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        din      = '0;

        // Reset state, then zero input.
        do_reset(3);
        chk("reset_dout", dout, '0);
        chk("reset_noX", {63'b0, $isunknown(dout)}, '0);
        frame('0, '0, "zero_e0");
        frame('0, '0, "zero_e1");
        frame('0, '0, "zero_e2");
        chk("zero_noX", {63'b0, $isunknown(dout)}, '0);

        // Impulse.
        do_reset(2);
        frame(64'h1, 64'h0, "imp_e0");
        frame(64'h0, 64'h1, "imp_e1");
        frame(64'h0, 64'h1, "imp_e2");
        frame(64'h0, 64'h1, "imp_e3");
        frame(64'h0, 64'h1, "imp_e4");
        frame(64'h0, 64'h0, "imp_e5");
        frame(64'h0, 64'h0, "imp_e6");

        // Overflow wraps mod 2^64; carry out of bit 63 is discarded.
        do_reset(2);
        frame(ONES, 64'h0,               "ovf_e0");
        frame(ONES, 64'hFFFFFFFFFFFFFFFF, "ovf_e1");
        frame(ONES, 64'hFFFFFFFFFFFFFFFE, "ovf_e2");
        frame(ONES, 64'hFFFFFFFFFFFFFFFD, "ovf_e3");
        frame(64'h0, 64'hFFFFFFFFFFFFFFFC, "ovf_e4");
        frame(64'h0, 64'hFFFFFFFFFFFFFFFD, "ovf_e5");
        frame(64'h0, 64'hFFFFFFFFFFFFFFFE, "ovf_e6");
        frame(64'h0, 64'hFFFFFFFFFFFFFFFF, "ovf_e7");
        frame(64'h0, 64'h0,               "ovf_e8");

        // Long carry chain.
        do_reset(2);
        frame(64'h7FFFFFFFFFFFFFFF, 64'h0,               "cry_e0");
        frame(64'h1,               64'h7FFFFFFFFFFFFFFF, "cry_e1");
        frame(64'h0,               64'h8000000000000000, "cry_e2");
        frame(64'h0,               64'h8000000000000000, "cry_e3");
        frame(64'h0,               64'h8000000000000000, "cry_e4");
        frame(64'h0,               64'h1,               "cry_e5");
        frame(64'h0,               64'h0,               "cry_e6");

        // Reset in the middle of a frame.
        do_reset(2);
        frame(64'h3, 64'h0,  "mid_e0");
        frame(64'h5, 64'h3,  "mid_e1");
        frame(64'h7, 64'h8,  "mid_e2");
        frame(64'h9, 64'hF,  "mid_e3");
        din = 64'hB;
        @(posedge clk);
        #1;
        chk("mid_e4", dout, 64'h18);
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst", dout, '0);
        @(negedge clk);
        reset = 1'b1;
        frame(64'h5, 64'h0, "mid_r0");
        frame(64'h0, 64'h5, "mid_r1");
        frame(64'h0, 64'h5, "mid_r2");
        frame(64'h0, 64'h5, "mid_r3");
        frame(64'h0, 64'h5, "mid_r4");
        frame(64'h0, 64'h0, "mid_r5");

        // Random words against a four-word history.
        do_reset(2);
        h1 = '0; h2 = '0; h3 = '0; h4 = '0;
        for (int i = 0; i < 1024; i++) begin
            w = {$urandom, $urandom};
            frame(w, h1 + h2 + h3 + h4, "rnd");
            h4 = h3; h3 = h2; h2 = h1; h1 = w;
        end
        frame('0, h1 + h2 + h3 + h4, "rnd_last");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
